// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_pkg
//  Purpose  : Shared constants for the data-memory responder: FSM state
//             encoding, default geometry/latency and the read-strobe value.
//  Revision : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // Default geometry and wait-state count
    localparam int DMEM_ADDR_W_DEF  = 10;
    localparam int DMEM_LATENCY_DEF = 2;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Byte-enable pattern that denotes a read
    localparam logic [3:0] WEN_READ = 4'b0000;

    // Captured request fields held for the duration of an access
    typedef struct packed {
        logic [3:0]  wen;
        logic [31:0] wdata;
    } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Purpose  : 2^ADDR_W x 32-bit synchronous RAM with four byte-lane write
//             enables and a registered read port.
//  Ports    : clk     - clock
//             rst     - asynchronous active-low reset (read register only)
//             wr_en   - write strobe, qualified per lane by wen
//             wen     - byte-lane enables, bit i covers wdata[8i+7:8i]
//             rd_en   - load the read register this edge
//             rd_clr  - when loading, load zero instead of the RAM word
//             idx     - word index
//             wdata   - write data
//             rdata   - registered read data
//  Revision : 1.0  initial release
// ============================================================================
module dmem_array
#(
    parameter int ADDR_W = 10
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        wen,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // Storage is deliberately not reset: contents survive rst.
    logic [31:0] r_mem [0:(1<<ADDR_W)-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) begin
                    r_mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register holds its value between reads so the CPU can sample it
    // any time after the access completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (rd_en) begin
            r_rdata <= rd_clr ? '0 : r_mem[idx];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Memory-side responder for the CPU data port. Models a word
//             organised RAM with LATENCY wait states; one access at a time.
//             Optional macro DMEM_RANGE_CHECK_EN flags and suppresses accesses
//             whose address has bits set above ADDR_W+1.
//  Ports    : clk   - clock
//             rst   - asynchronous active-low reset
//             en    - access request
//             wen   - byte write enables (0000 = read)
//             addr  - byte address, addr[1:0] ignored
//             wdata - lane-aligned write data
//             rdata - registered read data
//             stall - request not yet complete
//             err   - out-of-range flag, high only in the completion cycle
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W_DEF,
    parameter int LATENCY = DMEM_LATENCY_DEF
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err
);

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_idx;
    dmem_req_t         r_req;

    logic w_fire;
    logic w_is_read;
    logic w_oor;
    logic w_unused;

    // Final BUSY edge: the RAM is touched exactly here.
    assign w_fire    = (r_state == BUSY) && (r_cnt == 4'd0);
    assign w_is_read = (r_req.wen == WEN_READ);

    // Byte-offset bits never matter; upper bits matter only with range check.
    assign w_unused  = ^{addr[1:0], addr[31:ADDR_W+2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Request capture: later changes on the live inputs are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx <= '0;
            r_req <= '0;
        end else if ((r_state == IDLE) && en) begin
            r_idx       <= addr[ADDR_W+1:2];
            r_req.wen   <= wen;
            r_req.wdata <= wdata;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic r_oor;
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_oor <= 1'b0;
        end else if ((r_state == IDLE) && en) begin
            r_oor <= |addr[31:ADDR_W+2];
        end
    end

    // Set on the completing edge, so it is high for the DONE cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_fire && r_oor;
        end
    end

    assign w_oor = r_oor;
    assign err   = r_err;
`else
    assign w_oor = 1'b0;
    assign err   = 1'b0;
`endif

    // IDLE reflects en immediately so the CPU stalls in the request cycle.
    always_comb begin
        stall = 1'b0;
        case (r_state)
            IDLE:    stall = en;
            BUSY:    stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Out-of-range accesses never write and always clear rdata.
    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (w_fire && !w_is_read && !w_oor),
        .wen    (r_req.wen),
        .rd_en  (w_fire && (w_is_read || w_oor)),
        .rd_clr (w_oor),
        .idx    (r_idx),
        .wdata  (r_req.wdata),
        .rdata  (rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder: an access-level model
//             predicts stall/rdata/err every cycle, and directed accesses pin
//             the model with hand-computed read values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT = 3;
    localparam int AW  = 10;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        en    = 1'b0;
    logic [3:0]  wen   = 4'h0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        err;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W  (AW),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .wen   (wen),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .stall (stall),
        .err   (err)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- access-level model ----------------
    // phase < 0: no access in flight; 0..LAT-1: waiting; LAT: result cycle.
    logic [31:0] m_mem [0:(1<<AW)-1];
    int          phase   = -1;
    logic [31:0] c_addr  = 0;
    logic [31:0] c_wdata = 0;
    logic [3:0]  c_wen   = 0;
    logic [31:0] m_rdata = 0;
    logic        m_err   = 0;

    task automatic model_complete();
        bit          oor;
        int          idx;
        logic [31:0] mask;
`ifdef DMEM_RANGE_CHECK_EN
        oor = (c_addr >= 32'(1 << (AW + 2)));
`else
        oor = 1'b0;
`endif
        idx  = int'((c_addr % 32'(1 << (AW + 2))) / 4);
        mask = {{8{c_wen[3]}}, {8{c_wen[2]}}, {8{c_wen[1]}}, {8{c_wen[0]}}};
        if (oor) begin
            m_rdata = 32'h0;
        end else if (c_wen == 4'h0) begin
            m_rdata = m_mem[idx];
        end else begin
            m_mem[idx] = (m_mem[idx] & ~mask) | (c_wdata & mask);
        end
        m_err = oor;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase   = -1;
            m_rdata = 32'h0;
            m_err   = 1'b0;
        end else if (phase < 0) begin
            if (en) begin
                phase   = 0;
                c_addr  = addr;
                c_wen   = wen;
                c_wdata = wdata;
            end
        end else if (phase < LAT) begin
            phase++;
            if (phase == LAT) model_complete();
        end else begin
            phase = -1;
            m_err = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst && checking) begin
            chk("stall", 32'(stall), 32'((phase < 0) ? en : (phase < LAT)));
            chk("rdata", rdata, m_rdata);
            chk("err",   32'(err),   32'(m_err));
        end
    end

    // One complete access; returns the rdata/err seen in the result cycle.
    task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                          input bit keep, input bit corrupt,
                          output logic [31:0] rd, output logic er);
        int n;
        bit done;
        n    = 0;
        done = 0;
        @(posedge clk); #2;
        en = 1'b1; addr = a; wen = w; wdata = d;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
            end else begin
                n++;
                if (corrupt && n == 2) begin
                    addr = 32'h80; wen = 4'hF; wdata = 32'hFFFF_FFFF;
                end
            end
        end
        chk("stall_len", 32'(n), 32'(LAT + 1));
        rd = rdata;
        er = err;
        if (!keep) begin
            @(posedge clk); #2;
            en = 1'b0; wen = 4'h0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = 32'h0;

        // Reset state
        #1 rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err",   32'(err), 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        checking = 1;

        // Seed word 4, read it back so rdata is non-zero
        access(32'h10, 4'hF, 32'hCAFE_F00D, 0, 0, rd, er);
        access(32'h10, 4'h0, 32'h0,         0, 0, rd, er);
        chk("rd_0x10", rd, 32'hCAFE_F00D);

        // Reset in the middle of a write to word 4
        @(posedge clk); #2;
        en = 1'b1; addr = 32'h10; wen = 4'hF; wdata = 32'hDEAD_BEEF;
        @(negedge clk); @(negedge clk); @(negedge clk);
        #1 rst = 1'b0; en = 1'b0; wen = 4'h0;
        #1;
        chk("midrst_stall", 32'(stall), 32'h0);
        chk("midrst_rdata", rdata, 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        access(32'h10, 4'h0, 32'h0, 0, 0, rd, er);
        chk("rst_no_write", rd, 32'hCAFE_F00D);

        // Full write then read
        access(32'h40, 4'hF, 32'h1234_5678, 0, 0, rd, er);
        access(32'h40, 4'h0, 32'h0,         0, 0, rd, er);
        chk("rd_0x40", rd, 32'h1234_5678);

        // Single byte lane
        access(32'h40, 4'b0100, 32'h00AB_0000, 0, 0, rd, er);
        access(32'h40, 4'h0,    32'h0,         0, 0, rd, er);
        chk("rd_lane2", rd, 32'h12AB_5678);

        // Inputs changed during BUSY must not affect the captured read
        access(32'h80, 4'hF, 32'h55AA_55AA, 0, 0, rd, er);
        access(32'h40, 4'h0, 32'h0,         0, 1, rd, er);
        chk("rd_hold", rd, 32'h12AB_5678);
        access(32'h80, 4'h0, 32'h0,         0, 0, rd, er);
        chk("rd_0x80", rd, 32'h55AA_55AA);

        // Back-to-back reads with en held high across DONE
        access(32'h0, 4'hF, 32'h1111_1111, 0, 0, rd, er);
        access(32'h4, 4'hF, 32'h2222_2222, 0, 0, rd, er);
        access(32'h8, 4'hF, 32'h3333_3333, 0, 0, rd, er);
        access(32'h0, 4'h0, 32'h0, 1, 0, rd, er);
        chk("b2b_0", rd, 32'h1111_1111);
        access(32'h4, 4'h0, 32'h0, 1, 0, rd, er);
        chk("b2b_1", rd, 32'h2222_2222);
        access(32'h8, 4'h0, 32'h0, 0, 0, rd, er);
        chk("b2b_2", rd, 32'h3333_3333);

        // Address just beyond the RAM
        access(32'h0000_1000, 4'hF, 32'h9999_9999, 0, 0, rd, er);
`ifdef DMEM_RANGE_CHECK_EN
        chk("oor_err",   32'(er), 32'h1);
        chk("oor_rdata", rd, 32'h0);
        access(32'h0, 4'h0, 32'h0, 0, 0, rd, er);
        chk("oor_no_alias", rd, 32'h1111_1111);
`else
        chk("alias_err",   32'(er), 32'h0);
        chk("alias_rdata", rd, 32'h3333_3333);
        access(32'h0, 4'h0, 32'h0, 0, 0, rd, er);
        chk("alias_word0", rd, 32'h9999_9999);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
